// File: rtl/sincos_pkg.sv
// Shared constants for the iterative sine/cosine unit.
// All angles and CORDIC state use signed Q4.27 fixed point (32 bits).
// Holds the arctangent table, CORDIC gain, pi multiples and the FSM state type.
package sincos_pkg;

  localparam int N_ITER = 24;
  localparam int FRAC   = 27;

  // CORDIC gain compensation 0.6072529350 in Q4.27
  localparam logic signed [31:0] K_FIX       = 32'sd81504109;
  // pi, pi/2 and 2*pi in Q4.27 (rounded to nearest)
  localparam logic signed [31:0] PI_FIX      = 32'sd421657428;
  localparam logic signed [31:0] HALF_PI_FIX = 32'sd210828714;
  localparam logic signed [31:0] TWO_PI_FIX  = 32'sd843314857;

  localparam logic [31:0] QNAN   = 32'h7FC00000;
  localparam logic [31:0] FP_ONE = 32'h3F800000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REDUCE = 2'd1,
    ITER   = 2'd2,
    PACK   = 2'd3
  } state_t;

  // atan(2^-i) in Q4.27, i = 0 .. N_ITER-1
  function automatic logic signed [31:0] atan_tab(input logic [4:0] idx);
    logic signed [31:0] v;
    case (idx)
      5'd0:    v = 32'sd105414357;
      5'd1:    v = 32'sd62229729;
      5'd2:    v = 32'sd32880480;
      5'd3:    v = 32'sd16690645;
      5'd4:    v = 32'sd8377711;
      5'd5:    v = 32'sd4192940;
      5'd6:    v = 32'sd2096981;
      5'd7:    v = 32'sd1048555;
      5'd8:    v = 32'sd524285;
      5'd9:    v = 32'sd262144;
      5'd10:   v = 32'sd131072;
      5'd11:   v = 32'sd65536;
      5'd12:   v = 32'sd32768;
      5'd13:   v = 32'sd16384;
      5'd14:   v = 32'sd8192;
      5'd15:   v = 32'sd4096;
      5'd16:   v = 32'sd2048;
      5'd17:   v = 32'sd1024;
      5'd18:   v = 32'sd512;
      5'd19:   v = 32'sd256;
      5'd20:   v = 32'sd128;
      5'd21:   v = 32'sd64;
      5'd22:   v = 32'sd32;
      5'd23:   v = 32'sd16;
      default: v = 32'sd0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/fix2fp.sv
// Signed Q4.27 fixed point to IEEE-754 single precision converter.
// Latency: purely combinational.
// Backpressure: none; output follows input.
module fix2fp (
  input  logic [31:0] fix,
  output logic [31:0] fp
);

  logic        sign;
  logic [31:0] mag;
  logic [4:0]  lead;
  logic [31:0] norm;
  logic [7:0]  norm_unused_lsb;
  logic [7:0]  exp_b;

  // sign-magnitude split, leading-one detect, normalise and truncate
  always_comb begin
    sign = fix[31];
    mag  = sign ? (~fix + 32'd1) : fix;
    lead = 5'd0;
    for (int i = 0; i < 32; i++) begin
      if (mag[i]) lead = 5'(i);
    end
    // leading one lands on bit 31; bits 30:8 become the mantissa
    norm            = mag << (5'd31 - lead);
    norm_unused_lsb = norm[7:0];
    // value = mag * 2^-27, so unbiased exponent is lead-27, biased lead+100
    exp_b = {3'b000, lead} + 8'd100;
    // norm[31] is set exactly when the input is non-zero
    if (norm[31]) fp = {sign, exp_b, norm[30:8]};
    else          fp = 32'h0000_0000;
  end

endmodule

// File: rtl/fp_sincos.sv
// Iterative single-precision sin/cos: unpack, range reduce, rotation CORDIC, pack.
// Latency: sine_done pulses 26 clocks after the edge that samples sine_start.
// Backpressure: start is accepted only in IDLE; it is ignored while busy.
module fp_sincos
  import sincos_pkg::*;
(
  input  logic        clk,
  input  logic        n_rst,
  input  logic        sine_start,
  input  logic [31:0] opx,
  output logic        sine_done,
  output logic [31:0] sine_result,
  output logic [31:0] cosine_result
);

  state_t             state;
  logic [4:0]         iter;
  logic signed [31:0] x_in;
  logic               invalid_q;
  logic               zero_q;
  logic               neg_q;
  logic signed [31:0] cx;
  logic signed [31:0] cy;
  logic signed [31:0] cz;

  // unpack signals
  logic               in_sign;
  logic [7:0]         in_exp;
  logic [31:0]        in_mant;
  logic [31:0]        in_mag;
  logic signed [31:0] in_fix;
  logic               in_invalid;

  // reduction signals
  logic signed [31:0] red1;
  logic signed [31:0] red2;
  logic               red_neg;

  // iteration signals
  logic signed [31:0] x_sh;
  logic signed [31:0] y_sh;
  logic signed [31:0] atan_i;
  logic signed [31:0] x_nx;
  logic signed [31:0] y_nx;
  logic signed [31:0] z_nx;

  // pack signals
  logic signed [31:0] sin_fix;
  logic signed [31:0] cos_fix;
  logic [31:0]        sin_fp;
  logic [31:0]        cos_fp;

  // float to Q4.27: mantissa weight is 2^(exp-150), Q4.27 LSB is 2^-27,
  // so the 24-bit significand shifts left by exp-123 (truncating on right shifts)
  always_comb begin
    in_sign    = opx[31];
    in_exp     = opx[30:23];
    in_mant    = {8'h00, 1'b1, opx[22:0]};
    in_invalid = (in_exp == 8'hFF) || (in_exp >= 8'd130);
    if (in_exp == 8'd0 || in_invalid) begin
      in_mag = 32'd0;
    end else if (in_exp >= 8'd123) begin
      in_mag = in_mant << (in_exp - 8'd123);
    end else begin
      in_mag = in_mant >> (8'd123 - in_exp);
    end
    in_fix = in_sign ? -$signed(in_mag) : $signed(in_mag);
  end

  // fold into [-pi, pi], then into [-pi/2, pi/2] with a result sign flip
  always_comb begin
    red1 = x_in;
    if (x_in > PI_FIX)       red1 = x_in - TWO_PI_FIX;
    else if (x_in < -PI_FIX) red1 = x_in + TWO_PI_FIX;
    red2    = red1;
    red_neg = 1'b0;
    if (red1 > HALF_PI_FIX) begin
      red2    = red1 - PI_FIX;
      red_neg = 1'b1;
    end else if (red1 < -HALF_PI_FIX) begin
      red2    = red1 + PI_FIX;
      red_neg = 1'b1;
    end
  end

  // one rotation step; direction follows the sign of the residual angle
  always_comb begin
    x_sh   = cx >>> iter;
    y_sh   = cy >>> iter;
    atan_i = atan_tab(iter);
    if (cz[31]) begin
      x_nx = cx + y_sh;
      y_nx = cy - x_sh;
      z_nx = cz + atan_i;
    end else begin
      x_nx = cx - y_sh;
      y_nx = cy + x_sh;
      z_nx = cz - atan_i;
    end
  end

  // undo the half-turn fold before packing
  always_comb begin
    sin_fix = neg_q ? -cy : cy;
    cos_fix = neg_q ? -cx : cx;
  end

  fix2fp u_sin_pack (
    .fix (sin_fix),
    .fp  (sin_fp)
  );

  fix2fp u_cos_pack (
    .fix (cos_fix),
    .fp  (cos_fp)
  );

  // control FSM, CORDIC datapath registers and registered results
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state         <= IDLE;
      iter          <= 5'd0;
      x_in          <= '0;
      invalid_q     <= 1'b0;
      zero_q        <= 1'b0;
      neg_q         <= 1'b0;
      cx            <= '0;
      cy            <= '0;
      cz            <= '0;
      sine_done     <= 1'b0;
      sine_result   <= 32'h0;
      cosine_result <= 32'h0;
    end else begin
      sine_done <= 1'b0;
      case (state)
        IDLE: begin
          if (sine_start) begin
            x_in      <= in_fix;
            invalid_q <= in_invalid;
            // a zero angle leaves a small CORDIC residual in Y; short-circuit it
            zero_q    <= (in_fix == 32'sd0) && !in_invalid;
            state     <= REDUCE;
          end
        end
        REDUCE: begin
          cx    <= K_FIX;
          cy    <= 32'sd0;
          cz    <= red2;
          neg_q <= red_neg;
          iter  <= 5'd0;
          state <= ITER;
        end
        ITER: begin
          // special cases keep the same timing but leave the datapath idle
          if (!invalid_q && !zero_q) begin
            cx <= x_nx;
            cy <= y_nx;
            cz <= z_nx;
          end
          iter <= iter + 5'd1;
          if (iter == 5'(N_ITER - 1)) state <= PACK;
        end
        PACK: begin
          if (invalid_q) begin
            sine_result   <= QNAN;
            cosine_result <= QNAN;
          end else if (zero_q) begin
            sine_result   <= 32'h0;
            cosine_result <= FP_ONE;
          end else begin
            sine_result   <= sin_fp;
            cosine_result <= cos_fp;
          end
          sine_done <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_sincos.sv
// Directed self-checking bench for fp_sincos.
// Inputs driven and outputs sampled 1 time unit after each rising edge.
// Each task checks its own scenario; one summary line at the end.
module tb_fp_sincos;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        sine_start;
  logic [31:0] opx;
  logic        sine_done;
  logic [31:0] sine_result;
  logic [31:0] cosine_result;

  int tests = 0;
  int fails = 0;

  localparam real TOL = 9.5367431640625e-7;  // 2^-20

  fp_sincos dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .sine_start    (sine_start),
    .opx           (opx),
    .sine_done     (sine_done),
    .sine_result   (sine_result),
    .cosine_result (cosine_result)
  );

  always #5 clk = ~clk;

  function automatic real f2r(input logic [31:0] b);
    real m;
    int  e;
    if (b[30:23] == 8'd0) return 0.0;
    m = 1.0 + real'(int'(b[22:0])) / 8388608.0;
    e = int'(b[30:23]) - 127;
    if (e > 0) for (int k = 0; k < e; k++) m = m * 2.0;
    else       for (int k = 0; k < -e; k++) m = m / 2.0;
    return b[31] ? -m : m;
  endfunction

  function automatic real rabs(input real v);
    return (v < 0.0) ? -v : v;
  endfunction

  // called 1 unit after an edge; returns in the cycle done is seen high
  task automatic do_op(input logic [31:0] a, output logic [31:0] s,
                       output logic [31:0] c, output int lat);
    opx        = a;
    sine_start = 1'b1;
    @(posedge clk); #1;
    sine_start = 1'b0;
    lat = 0;
    while (sine_done !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    s = sine_result;
    c = cosine_result;
  endtask

  task automatic test_reset;
    #2 n_rst = 1'b0;
    #1;
    tests++;
    if (sine_done !== 1'b0) begin
      fails++; $display("FAIL reset_done got %b want 0", sine_done);
    end
    tests++;
    if (sine_result !== 32'h0) begin
      fails++; $display("FAIL reset_sin got %h want 00000000", sine_result);
    end
    tests++;
    if (cosine_result !== 32'h0) begin
      fails++; $display("FAIL reset_cos got %h want 00000000", cosine_result);
    end
    repeat (2) @(posedge clk);
    #1 n_rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_pi4;
    logic [31:0] s, c;
    int lat;
    do_op(32'h3F490FD8, s, c, lat);
    tests++;
    if (lat != 26) begin
      fails++; $display("FAIL pi4_latency got %0d want 26", lat);
    end
    tests++;
    if (rabs(f2r(s) - 0.7071066702) > TOL) begin
      fails++; $display("FAIL pi4_sin got %h (%f) want 0.7071067", s, f2r(s));
    end
    tests++;
    if (rabs(f2r(c) - 0.7071068922) > TOL) begin
      fails++; $display("FAIL pi4_cos got %h (%f) want 0.7071069", c, f2r(c));
    end
    @(posedge clk); #1;
    tests++;
    if (sine_done !== 1'b0) begin
      fails++; $display("FAIL pi4_done_width got %b want 0 one cycle after done", sine_done);
    end
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (rabs(f2r(sine_result) - 0.7071066702) > TOL) begin
      fails++; $display("FAIL pi4_hold got %h want 0.7071067 held", sine_result);
    end
  endtask

  task automatic test_angles;
    logic [31:0] ang [9];
    real         es  [9];
    real         ec  [9];
    logic [31:0] s, c;
    int lat;
    ang[0] = 32'h3FC90FD8; es[0] =  1.0;          ec[0] =  0.0;           // pi/2
    ang[1] = 32'h4096CBE4; es[1] = -1.0;          ec[1] =  0.0;           // 3pi/2
    ang[2] = 32'h40AFEDDF; es[2] = -0.7071067812; ec[2] =  0.7071067812;  // 7pi/4
    ang[3] = 32'h40C90FDB; es[3] =  0.0;          ec[3] =  1.0;           // 2pi
    ang[4] = 32'h40400000; es[4] =  0.1411200081; ec[4] = -0.9899924966;  // 3.0
    ang[5] = 32'hC0000000; es[5] = -0.9092974268; ec[5] = -0.4161468365;  // -2.0
    ang[6] = 32'hC0800000; es[6] =  0.7568024953; ec[6] = -0.6536436209;  // -4.0
    ang[7] = 32'hC0F00000; es[7] = -0.9379999768; ec[7] =  0.3466353178;  // -7.5
    ang[8] = 32'h40FFFFFF; es[8] =  0.9893583160; ec[8] = -0.1454995620;  // just below 8
    for (int i = 0; i < 9; i++) begin
      do_op(ang[i], s, c, lat);
      tests++;
      if (rabs(f2r(s) - es[i]) > TOL) begin
        fails++; $display("FAIL angle%0d_sin opx=%h got %h (%f) want %f", i, ang[i], s, f2r(s), es[i]);
      end
      tests++;
      if (rabs(f2r(c) - ec[i]) > TOL) begin
        fails++; $display("FAIL angle%0d_cos opx=%h got %h (%f) want %f", i, ang[i], c, f2r(c), ec[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_zero;
    logic [31:0] z [3];
    logic [31:0] s, c;
    int lat;
    z[0] = 32'h00000000; z[1] = 32'h80000000; z[2] = 32'h00000001;
    for (int i = 0; i < 3; i++) begin
      do_op(z[i], s, c, lat);
      tests++;
      if (s !== 32'h0) begin
        fails++; $display("FAIL zero%0d_sin opx=%h got %h want 00000000", i, z[i], s);
      end
      tests++;
      if (rabs(f2r(c) - 1.0) > TOL) begin
        fails++; $display("FAIL zero%0d_cos opx=%h got %h want 1.0", i, z[i], c);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_invalid;
    logic [31:0] v [4];
    logic [31:0] s, c;
    int lat;
    v[0] = 32'h7F800000; v[1] = 32'h41200000; v[2] = 32'h7FC00001; v[3] = 32'hC1000000;
    for (int i = 0; i < 4; i++) begin
      do_op(v[i], s, c, lat);
      tests++;
      if (s !== 32'h7FC00000 || c !== 32'h7FC00000) begin
        fails++; $display("FAIL invalid%0d opx=%h got sin=%h cos=%h want 7fc00000", i, v[i], s, c);
      end
      tests++;
      if (lat != 26) begin
        fails++; $display("FAIL invalid%0d_latency got %0d want 26", i, lat);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_busy_start;
    int dones = 0;
    int done_edge = -1;
    logic [31:0] s = 32'h0;
    logic [31:0] c = 32'h0;
    opx        = 32'h3F000000;  // 0.5
    sine_start = 1'b1;
    @(posedge clk); #1;
    sine_start = 1'b0;
    for (int k = 1; k < 60; k++) begin
      if (k == 3) begin
        sine_start = 1'b1;
        opx        = 32'h41200000;
      end
      if (k == 20) sine_start = 1'b0;
      @(posedge clk); #1;
      if (sine_done === 1'b1) begin
        dones++;
        if (done_edge < 0) done_edge = k;
        s = sine_result;
        c = cosine_result;
      end
    end
    tests++;
    if (dones != 1) begin
      fails++; $display("FAIL busy_done_count got %0d want 1", dones);
    end
    tests++;
    if (done_edge != 26) begin
      fails++; $display("FAIL busy_done_edge got %0d want 26", done_edge);
    end
    tests++;
    if (rabs(f2r(s) - 0.4794255386) > TOL || rabs(f2r(c) - 0.8775825619) > TOL) begin
      fails++; $display("FAIL busy_result got sin=%h cos=%h want 0.4794255 0.8775826", s, c);
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] s, c;
    int lat;
    opx        = 32'hBF000000;  // -0.5
    sine_start = 1'b1;
    @(posedge clk); #1;
    sine_start = 1'b0;
    repeat (10) @(posedge clk);
    #1 n_rst = 1'b0;
    #1;
    tests++;
    if (sine_done !== 1'b0 || sine_result !== 32'h0 || cosine_result !== 32'h0) begin
      fails++; $display("FAIL midreset_clear got done=%b sin=%h cos=%h want 0 0 0", sine_done, sine_result, cosine_result);
    end
    @(posedge clk); #1;
    n_rst = 1'b1;
    @(posedge clk); #1;
    do_op(32'hBF000000, s, c, lat);
    tests++;
    if (lat != 26) begin
      fails++; $display("FAIL midreset_latency got %0d want 26", lat);
    end
    tests++;
    if (rabs(f2r(s) + 0.4794255386) > TOL) begin
      fails++; $display("FAIL midreset_sin got %h want -0.4794255", s);
    end
    tests++;
    if (rabs(f2r(c) - 0.8775825619) > TOL) begin
      fails++; $display("FAIL midreset_cos got %h want 0.8775826", c);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    logic [31:0] s, c;
    int lat;
    do_op(32'h3F800000, s, c, lat);  // 1.0
    tests++;
    if (rabs(f2r(s) - 0.8414709848) > TOL || rabs(f2r(c) - 0.5403023059) > TOL) begin
      fails++; $display("FAIL b2b_first got sin=%h cos=%h want 0.8414710 0.5403023", s, c);
    end
    // restart in the very cycle done is high
    do_op(32'h40000000, s, c, lat);  // 2.0
    tests++;
    if (lat != 26) begin
      fails++; $display("FAIL b2b_latency got %0d want 26", lat);
    end
    tests++;
    if (rabs(f2r(s) - 0.9092974268) > TOL || rabs(f2r(c) + 0.4161468365) > TOL) begin
      fails++; $display("FAIL b2b_second got sin=%h cos=%h want 0.9092974 -0.4161468", s, c);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    n_rst      = 1'b1;
    sine_start = 1'b0;
    opx        = 32'h0;
    test_reset;
    test_pi4;
    test_angles;
    test_zero;
    test_invalid;
    test_busy_start;
    test_reset_mid;
    test_back_to_back;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
